// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift sequencer: command and shifter op encodings,
// FSM state encoding, step limit, and the single-step shift function used by
// both the shifter datapath and the sequencer's result capture.
package shift_seq_pkg;

    localparam int DW       = 8;
    localparam int AMT_W    = 3;
    localparam int STEP_MAX = 3;

    // Requester command encodings
    localparam logic [1:0] CMD_LSL = 2'b00;
    localparam logic [1:0] CMD_LSR = 2'b01;
    localparam logic [1:0] CMD_ASR = 2'b10;
    localparam logic [1:0] CMD_RSV = 2'b11;

    // shifter8 op encodings
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_LSL  = 3'b010;
    localparam logic [2:0] OP_LSR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SHIFT = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    // Value the shifter register will hold after one edge with the given op.
    function automatic logic [DW-1:0] shift_apply(
        input logic [2:0]    op,
        input logic [DW-1:0] cur,
        input logic [DW-1:0] din,
        input logic [1:0]    shamt
    );
        logic signed [DW-1:0] cur_s;
        cur_s = $signed(cur);
        case (op)
            OP_LOAD: return din;
            OP_LSL:  return cur << shamt;
            OP_LSR:  return cur >> shamt;
            OP_ASR:  return $unsigned(cur_s >>> shamt);
            default: return cur;
        endcase
    endfunction

endpackage

// File: rtl/shift_seq_if.sv
// Request/response bundle between a requester and the shift sequencer.
// Optional macro SHIFT_SEQ_ABORT_EN adds the abort request line.
interface shift_seq_if;
    import shift_seq_pkg::*;

    logic            start;
    logic            ready;
    logic [1:0]      cmd;
    logic [AMT_W-1:0] amount;
    logic [DW-1:0]   d_in;
    logic            done;
    logic [DW-1:0]   result;
`ifdef SHIFT_SEQ_ABORT_EN
    logic            abort;
`endif

    modport master (
        output start, cmd, amount, d_in,
`ifdef SHIFT_SEQ_ABORT_EN
        output abort,
`endif
        input  ready, done, result
    );

    modport slave (
        input  start, cmd, amount, d_in,
`ifdef SHIFT_SEQ_ABORT_EN
        input  abort,
`endif
        output ready, done, result
    );

endinterface

// File: rtl/shifter8.sv
// 8-bit registered shifter: load, hold, or shift by 0..3 positions per edge.
module shifter8
    import shift_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    op,
    input  logic [1:0]    shamt,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] d_out
);

    logic [DW-1:0] d_out_d;
    logic [DW-1:0] d_out_q;

    // next register value for the requested op
    always_comb begin
        d_out_d = shift_apply(op, d_out_q, d_in, shamt);
    end

    // data register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            d_out_q <= '0;
        end else begin
            d_out_q <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle 0..7-bit shift sequencer driving one shifter8.
// Optional macro SHIFT_SEQ_ABORT_EN enables abort of LOAD/SHIFT.
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | ready=1, waiting for start; latches cmd/amount/operand
// LOAD     | shifter loads the latched operand
// SHIFT    | shifter steps by min(rem,3) until rem reaches 0
// DONE     | done pulse; result already holds the final value
module shift_seq
    import shift_seq_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    shift_seq_if.slave bus
);

    state_t           state_d, state_q;
    logic [AMT_W-1:0] rem_d, rem_q;
    logic [1:0]       cmd_d, cmd_q;
    logic [DW-1:0]    opnd_d, opnd_q;
    logic [DW-1:0]    result_d, result_q;

    logic [2:0]       sh_op;
    logic [1:0]       sh_amt;
    logic [1:0]       step;
    logic [DW-1:0]    sh_dout;
    logic             abort_w;

`ifdef SHIFT_SEQ_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    // largest step the shifter can take toward the remaining count
    assign step = (rem_q > AMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];

    // FSM next-state, step counter and shifter control
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        cmd_d    = cmd_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        sh_op    = OP_NOP;
        sh_amt   = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cmd_d   = bus.cmd;
                    opnd_d  = bus.d_in;
                    // reserved command passes the operand through unshifted
                    rem_d   = (bus.cmd == CMD_RSV) ? '0 : bus.amount;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sh_op   = OP_LOAD;
                state_d = (rem_q != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                case (cmd_q)
                    CMD_LSL: sh_op = OP_LSL;
                    CMD_LSR: sh_op = OP_LSR;
                    CMD_ASR: sh_op = OP_ASR;
                    default: sh_op = OP_NOP;
                endcase
                sh_amt = step;
                rem_d  = rem_q - AMT_W'(step);
                if (rem_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_w && (state_q == ST_LOAD || state_q == ST_SHIFT)) begin
            state_d = ST_IDLE;
            sh_op   = OP_NOP;
            sh_amt  = 2'd0;
            rem_d   = '0;
        end

        // capture what the shifter will hold after this edge so result and
        // done become visible in the same cycle
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            result_d = shift_apply(sh_op, sh_dout, opnd_q, sh_amt);
        end
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rem_q    <= '0;
            cmd_q    <= CMD_LSL;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            cmd_q    <= cmd_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    shifter8 u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (sh_op),
        .shamt   (sh_amt),
        .d_in    (opnd_q),
        .d_out   (sh_dout)
    );

    assign bus.ready  = (state_q == ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq.
// Optional macro SHIFT_SEQ_ABORT_EN adds the abort scenario.
module tb_shift_seq;
    import shift_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    shift_seq_if bus_if();

    shift_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge and follow it through to done.
    task automatic run_req(input string tag, input logic [1:0] c, input logic [2:0] a,
                           input logic [7:0] d, input logic [7:0] exp_res);
        int n;
        int lat;
        logic [7:0] held;
        lat = (c == CMD_RSV) ? 1 : 1 + (int'(a) + 2) / 3;
        check1({tag, "_ready_idle"}, bus_if.ready, 1'b1);
        bus_if.start  = 1'b1;
        bus_if.cmd    = c;
        bus_if.amount = a;
        bus_if.d_in   = d;
        @(negedge clk);
        bus_if.start  = 1'b0;
        bus_if.cmd    = 2'($urandom);
        bus_if.amount = 3'($urandom);
        bus_if.d_in   = 8'($urandom);
        check1({tag, "_ready_busy"}, bus_if.ready, 1'b0);
        n = 0;
        while (bus_if.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checki({tag, "_latency"}, n, lat);
        check8({tag, "_result"}, bus_if.result, exp_res);
        held = exp_res;
        @(negedge clk);
        check1({tag, "_done_pulse"}, bus_if.done, 1'b0);
        check1({tag, "_ready_back"}, bus_if.ready, 1'b1);
        check8({tag, "_result_held"}, bus_if.result, held);
    endtask

    initial begin
        int n;
        int dones;
        bus_if.start  = 1'b0;
        bus_if.cmd    = CMD_LSL;
        bus_if.amount = 3'd0;
        bus_if.d_in   = 8'h00;
`ifdef SHIFT_SEQ_ABORT_EN
        bus_if.abort  = 1'b0;
`endif
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check1("rst_ready", bus_if.ready, 1'b1);
        check1("rst_done", bus_if.done, 1'b0);
        check8("rst_result", bus_if.result, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        run_req("lsl5", CMD_LSL, 3'd5, 8'h77, 8'hE0);

`ifdef SHIFT_SEQ_ABORT_EN
        // abort during the second SHIFT step of an LSR by 7
        bus_if.start  = 1'b1;
        bus_if.cmd    = CMD_LSR;
        bus_if.amount = 3'd7;
        bus_if.d_in   = 8'h87;
        @(negedge clk);
        bus_if.start  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus_if.abort  = 1'b1;
        @(negedge clk);
        bus_if.abort  = 1'b0;
        check1("abort_ready", bus_if.ready, 1'b1);
        check1("abort_done", bus_if.done, 1'b0);
        check8("abort_result", bus_if.result, 8'hE0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) dones++;
        end
        checki("abort_no_done", dones, 0);
`endif

        run_req("lsr7", CMD_LSR, 3'd7, 8'h87, 8'h01);
        run_req("asr7", CMD_ASR, 3'd7, 8'h87, 8'hFF);
        run_req("asr4", CMD_ASR, 3'd4, 8'h87, 8'hF8);
        run_req("amt0", CMD_LSL, 3'd0, 8'hA5, 8'hA5);
        run_req("rsv6", CMD_RSV, 3'd6, 8'h3C, 8'h3C);
        run_req("lsl3", CMD_LSL, 3'd3, 8'h81, 8'h08);

        // start held through a busy LSL by 7; second request waits for ready
        bus_if.start  = 1'b1;
        bus_if.cmd    = CMD_LSL;
        bus_if.amount = 3'd7;
        bus_if.d_in   = 8'h03;
        @(negedge clk);
        bus_if.cmd    = CMD_LSR;
        bus_if.amount = 3'd1;
        bus_if.d_in   = 8'hF0;
        n = 0;
        while (bus_if.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checki("busy_first_latency", n, 4);
        check8("busy_first_result", bus_if.result, 8'h80);
        @(negedge clk);
        check1("busy_ready_back", bus_if.ready, 1'b1);
        check8("busy_result_held", bus_if.result, 8'h80);
        @(negedge clk);
        bus_if.start = 1'b0;
        check1("busy_second_accepted", bus_if.ready, 1'b0);
        n = 0;
        while (bus_if.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checki("busy_second_latency", n, 2);
        check8("busy_second_result", bus_if.result, 8'h78);
        @(negedge clk);

        // reset during SHIFT of an ASR by 7
        bus_if.start  = 1'b1;
        bus_if.cmd    = CMD_ASR;
        bus_if.amount = 3'd7;
        bus_if.d_in   = 8'h87;
        @(negedge clk);
        bus_if.start  = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check1("midrst_ready", bus_if.ready, 1'b1);
        check1("midrst_done", bus_if.done, 1'b0);
        check8("midrst_result", bus_if.result, 8'h00);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_if.done === 1'b1) dones++;
        end
        checki("midrst_no_done", dones, 0);

        run_req("post_rst_lsr2", CMD_LSR, 3'd2, 8'hFF, 8'h3F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle sequencer that drives one shifter8 instance to perform an arbitrary 0..7-bit shift of an 8-bit operand.
- shifter8 shifts at most 3 positions per cycle (2-bit shamt), so the block loads the operand and then issues as many shift steps as needed.
- Requesters use a start/ready handshake.
- The block returns a registered result with a one-cycle done pulse.

Parameters:
- DW, 8, data width; only 8 is supported because shifter8 is fixed-width.
- AMT_W, 3, width of the requested shift amount (0..7).
- STEP_MAX, 3, maximum shift per shifter8 op, equal to the largest shamt value.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset. One clock; reset is sampled on the rising edge of clk.
- start  in  1  request valid.
- ready  out  1  block can accept a request; high only in IDLE.
- cmd  in  2  00 LSL, 01 LSR, 10 ASR, 11 reserved.
- amount  in  3  total shift count.
- d_in  in  8  operand.
- done  out  1  one-cycle pulse; result is valid.
- result  out  8  final shifted value, held until the next done.

Behaviour:
- Reset (reset_n low at posedge, including mid-operation):
  - state goes to IDLE; ready=1, done=0, result=8'h00.
  - The internal shifter8 receives the same reset_n, so its d_out=0.
  - Any in-flight request is discarded.
- shifter8 op codes driven by the block: 000 NOP (hold), 001 LOAD, 010 LSL, 011 LSR, 100 ASR. shamt shifts by 0..3.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE:
    - ready=1, op=NOP.
    - On posedge with start=1, latch cmd, amount and d_in into internal registers: rem<=amount.
    - Next state is LOAD.
    - cmd=11 forces rem<=0, so the operand passes through unshifted.
  - LOAD:
    - op=LOAD, shifter d_in = latched operand.
    - Next state is SHIFT if rem!=0, otherwise DONE.
  - SHIFT:
    - op = LSL/LSR/ASR from the latched cmd; shamt = min(rem, 3).
    - Each posedge: rem <= rem - shamt.
    - When rem - shamt == 0, next state is DONE.
  - DONE:
    - op=NOP, done=1 for exactly this cycle.
    - result <= shifter d_out on the exiting edge. result is registered, so done and the new value coincide: result is updated on entry into DONE, sampled from d_out combinationally.
    - Next state is IDLE.
- Latency:
  - Request accepted at edge k.
  - done is high in the cycle after edge k+1+ceil(amount/3).
  - ready returns one edge later.
  - Step counts: amount 0 gives 0 steps; 1-3 give 1; 4-6 give 2; 7 gives 3 (3,3,1).
- start while ready=0 is ignored and not queued. The requester must hold start until it sees ready=1 at the edge.
- cmd, amount and d_in are don't-care outside the accept edge.
- Arithmetic:
  - LSL/LSR zero-fill.
  - ASR replicates bit 7.
  - The step splitting must give the same result as a single shift by amount.

Optional Feature:
- Macro SHIFT_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 at a posedge while in LOAD or SHIFT sends the FSM to IDLE next cycle with op=NOP.
  - No done pulse; result is unchanged.
  - abort in IDLE or DONE has no effect.
- When not defined: the port is absent and every accepted request always completes.

Decomposition:
- Package shift_seq_pkg holds:
  - the cmd encodings (CMD_LSL/LSR/ASR/RSV),
  - the shifter8 op constants (OP_NOP/LOAD/LSL/LSR/ASR),
  - the FSM state enum,
  - STEP_MAX.
- One sub-module: the existing shifter8, instantiated once, sharing clk and reset_n.
- The FSM and step counter live in shift_seq itself.

Test Plan:
- Reset, then LSL by 5 of 8'h77 -> steps 3,2; done 3 edges after accept; result 8'hE0.
- LSR by 7 of 8'h87 -> steps 3,3,1; result 8'h01; ASR by 7 of 8'h87 -> 8'hFF; ASR by 4 of 8'h87 -> 8'hF8.
- amount 0 with 8'hA5, and cmd=11 with amount 6 and 8'h3C -> result equals the operand; done 1 edge after LOAD.
- start held high during a busy LSL by 7, with different operands -> ignored; only the first request produces done; the second is accepted only when ready=1.
- reset_n low during SHIFT of an ASR by 7 -> next cycle ready=1, done=0, result=8'h00; no done pulse afterwards.
- With SHIFT_SEQ_ABORT_EN: abort during the second SHIFT step -> IDLE, no done, result keeps its previous value (e.g. 8'hE0).
